// File: rtl/axil_memory_arbiter.sv
// Two-master, one-slave AXI-lite arbiter in front of a shared RAM.
// The instruction fetch port (read-only) and the data port (read/write)
// take turns with round-robin fairness. Only one transaction is outstanding
// at a time. Address, data and strobe are routed combinationally and never
// registered; the arbiter adds only grant state and two write-progress flags.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no owner; all handshakes blocked; arbitrate on current valids
// INSTR_READ | instruction AR/R routed to the RAM until the R handshake
// DATA_READ  | data AR/R routed to the RAM until the R handshake
// DATA_WRITE | data AW/W/B routed to the RAM until the B handshake
//
// The state encoding is chosen so that it equals o_Grant directly.

module axil_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,

    // instruction side, read only
    input  logic [ADDR_WIDTH-1:0] s_instr_axil_araddr,
    input  logic                  s_instr_axil_arvalid,
    output logic                  s_instr_axil_arready,
    output logic [DATA_WIDTH-1:0] s_instr_axil_rdata,
    output logic                  s_instr_axil_rvalid,
    input  logic                  s_instr_axil_rready,

    // data side, read/write
    input  logic [ADDR_WIDTH-1:0] s_data_axil_araddr,
    input  logic                  s_data_axil_arvalid,
    output logic                  s_data_axil_arready,
    output logic [DATA_WIDTH-1:0] s_data_axil_rdata,
    output logic                  s_data_axil_rvalid,
    input  logic                  s_data_axil_rready,
    input  logic [ADDR_WIDTH-1:0] s_data_axil_awaddr,
    input  logic                  s_data_axil_awvalid,
    output logic                  s_data_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_data_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_data_axil_wstrb,
    input  logic                  s_data_axil_wvalid,
    output logic                  s_data_axil_wready,
    output logic [1:0]            s_data_axil_bresp,
    output logic                  s_data_axil_bvalid,
    input  logic                  s_data_axil_bready,

    // shared RAM side
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [1:0]            o_Grant
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        INSTR_READ = 2'b01,
        DATA_READ  = 2'b10,
        DATA_WRITE = 2'b11
    } state_t;

    state_t state;
    state_t next_state;
    logic   r_Last_Data;
    logic   r_Aw_Done;
    logic   r_W_Done;

    logic   instr_req;
    logic   data_req;
    logic   grant_data;
    logic   grant_instr;
    logic   r_done;
    logic   b_done;
    logic   aw_hs;
    logic   w_hs;

    // Data wins when alone or when the instruction side was served last.
    assign instr_req   = s_instr_axil_arvalid;
    assign data_req    = s_data_axil_arvalid | s_data_axil_awvalid;
    assign grant_data  = (state == IDLE) && data_req && (!instr_req || !r_Last_Data);
    assign grant_instr = (state == IDLE) && instr_req && !grant_data;

    assign r_done = m_axil_rvalid & m_axil_rready;
    assign b_done = m_axil_bvalid & m_axil_bready;
    assign aw_hs  = m_axil_awvalid & m_axil_awready;
    assign w_hs   = m_axil_wvalid & m_axil_wready;

    // Payload is pure routing; only valid/ready are steered by the state.
    assign m_axil_awaddr      = s_data_axil_awaddr;
    assign m_axil_wdata       = s_data_axil_wdata;
    assign m_axil_wstrb       = s_data_axil_wstrb;
    assign s_instr_axil_rdata = m_axil_rdata;
    assign s_data_axil_rdata  = m_axil_rdata;
    assign s_data_axil_bresp  = m_axil_bresp;
    assign o_Grant            = state;

    // State register
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: arbitrate in IDLE, hold each grant until its final response
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    next_state = s_data_axil_awvalid ? DATA_WRITE : DATA_READ;
                end else if (grant_instr) begin
                    next_state = INSTR_READ;
                end
            end
            INSTR_READ: if (r_done) next_state = IDLE;
            DATA_READ:  if (r_done) next_state = IDLE;
            DATA_WRITE: if (b_done) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Round-robin memory and write-channel progress flags
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Last_Data <= 1'b0;
            r_Aw_Done   <= 1'b0;
            r_W_Done    <= 1'b0;
        end else begin
            if (grant_data) begin
                r_Last_Data <= 1'b1;
            end else if (grant_instr) begin
                r_Last_Data <= 1'b0;
            end

            if (state != DATA_WRITE || b_done) begin
                r_Aw_Done <= 1'b0;
                r_W_Done  <= 1'b0;
            end else begin
                if (aw_hs) r_Aw_Done <= 1'b1;
                if (w_hs)  r_W_Done  <= 1'b1;
            end
        end
    end

    // Output routing: connect only the owner's channels, everything else idle
    always_comb begin
        s_instr_axil_arready = 1'b0;
        s_instr_axil_rvalid  = 1'b0;
        s_data_axil_arready  = 1'b0;
        s_data_axil_rvalid   = 1'b0;
        s_data_axil_awready  = 1'b0;
        s_data_axil_wready   = 1'b0;
        s_data_axil_bvalid   = 1'b0;
        m_axil_araddr        = s_data_axil_araddr;
        m_axil_arvalid       = 1'b0;
        m_axil_rready        = 1'b0;
        m_axil_awvalid       = 1'b0;
        m_axil_wvalid        = 1'b0;
        m_axil_bready        = 1'b0;
        case (state)
            INSTR_READ: begin
                m_axil_araddr        = s_instr_axil_araddr;
                m_axil_arvalid       = s_instr_axil_arvalid;
                s_instr_axil_arready = m_axil_arready;
                s_instr_axil_rvalid  = m_axil_rvalid;
                m_axil_rready        = s_instr_axil_rready;
            end
            DATA_READ: begin
                m_axil_araddr       = s_data_axil_araddr;
                m_axil_arvalid      = s_data_axil_arvalid;
                s_data_axil_arready = m_axil_arready;
                s_data_axil_rvalid  = m_axil_rvalid;
                m_axil_rready       = s_data_axil_rready;
            end
            DATA_WRITE: begin
                // Each address/data beat is forwarded exactly once.
                m_axil_awvalid      = s_data_axil_awvalid & ~r_Aw_Done;
                s_data_axil_awready = m_axil_awready & ~r_Aw_Done;
                m_axil_wvalid       = s_data_axil_wvalid & ~r_W_Done;
                s_data_axil_wready  = m_axil_wready & ~r_W_Done;
                s_data_axil_bvalid  = m_axil_bvalid;
                m_axil_bready       = s_data_axil_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_memory_arbiter.sv
// Bench for axil_memory_arbiter: a small behavioural AXI-lite RAM sits on the
// m side; directed transactions from a vector table plus hand sequences for
// contention, write ordering, split write channels, backpressure and reset.

module tb_axil_memory_arbiter;

    logic        clk;
    logic        rst;

    logic [31:0] s_instr_araddr;
    logic        s_instr_arvalid;
    logic        s_instr_arready;
    logic [31:0] s_instr_rdata;
    logic        s_instr_rvalid;
    logic        s_instr_rready;

    logic [31:0] s_data_araddr;
    logic        s_data_arvalid;
    logic        s_data_arready;
    logic [31:0] s_data_rdata;
    logic        s_data_rvalid;
    logic        s_data_rready;
    logic [31:0] s_data_awaddr;
    logic        s_data_awvalid;
    logic        s_data_awready;
    logic [31:0] s_data_wdata;
    logic [3:0]  s_data_wstrb;
    logic        s_data_wvalid;
    logic        s_data_wready;
    logic [1:0]  s_data_bresp;
    logic        s_data_bvalid;
    logic        s_data_bready;

    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    axil_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_Clock              (clk),
        .i_Reset              (rst),
        .s_instr_axil_araddr  (s_instr_araddr),
        .s_instr_axil_arvalid (s_instr_arvalid),
        .s_instr_axil_arready (s_instr_arready),
        .s_instr_axil_rdata   (s_instr_rdata),
        .s_instr_axil_rvalid  (s_instr_rvalid),
        .s_instr_axil_rready  (s_instr_rready),
        .s_data_axil_araddr   (s_data_araddr),
        .s_data_axil_arvalid  (s_data_arvalid),
        .s_data_axil_arready  (s_data_arready),
        .s_data_axil_rdata    (s_data_rdata),
        .s_data_axil_rvalid   (s_data_rvalid),
        .s_data_axil_rready   (s_data_rready),
        .s_data_axil_awaddr   (s_data_awaddr),
        .s_data_axil_awvalid  (s_data_awvalid),
        .s_data_axil_awready  (s_data_awready),
        .s_data_axil_wdata    (s_data_wdata),
        .s_data_axil_wstrb    (s_data_wstrb),
        .s_data_axil_wvalid   (s_data_wvalid),
        .s_data_axil_wready   (s_data_wready),
        .s_data_axil_bresp    (s_data_bresp),
        .s_data_axil_bvalid   (s_data_bvalid),
        .s_data_axil_bready   (s_data_bready),
        .m_axil_araddr        (m_araddr),
        .m_axil_arvalid       (m_arvalid),
        .m_axil_arready       (m_arready),
        .m_axil_rdata         (m_rdata),
        .m_axil_rvalid        (m_rvalid),
        .m_axil_rready        (m_rready),
        .m_axil_awaddr        (m_awaddr),
        .m_axil_awvalid       (m_awvalid),
        .m_axil_awready       (m_awready),
        .m_axil_wdata         (m_wdata),
        .m_axil_wstrb         (m_wstrb),
        .m_axil_wvalid        (m_wvalid),
        .m_axil_wready        (m_wready),
        .m_axil_bresp         (m_bresp),
        .m_axil_bvalid        (m_bvalid),
        .m_axil_bready        (m_bready),
        .o_Grant              (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM (256 words, shares the reset) -------
    logic [31:0] mem [0:255];
    logic        ram_rvalid;
    logic [31:0] ram_rdata;
    logic        ram_bvalid;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        ram_aw_hs;
    logic        ram_w_hs;
    logic        aw_have;
    logic        w_have;
    logic [31:0] aw_addr_eff;
    logic [31:0] w_data_eff;
    logic [3:0]  w_strb_eff;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_0013;
        return {16'hA5A5, 16'(i)};
    endfunction

    assign m_arready   = !ram_rvalid;
    assign m_rvalid    = ram_rvalid;
    assign m_rdata     = ram_rdata;
    assign m_awready   = !aw_got && !ram_bvalid;
    assign m_wready    = !w_got && !ram_bvalid;
    assign m_bvalid    = ram_bvalid;
    assign m_bresp     = 2'b00;
    assign ram_aw_hs   = m_awvalid && m_awready;
    assign ram_w_hs    = m_wvalid && m_wready;
    assign aw_have     = aw_got || ram_aw_hs;
    assign w_have      = w_got || ram_w_hs;
    assign aw_addr_eff = ram_aw_hs ? m_awaddr : aw_addr_q;
    assign w_data_eff  = ram_w_hs ? m_wdata : w_data_q;
    assign w_strb_eff  = ram_w_hs ? m_wstrb : w_strb_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rvalid <= 1'b0;
            ram_rdata  <= 32'h0;
            ram_bvalid <= 1'b0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_addr_q  <= 32'h0;
            w_data_q   <= 32'h0;
            w_strb_q   <= 4'h0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (m_arvalid && m_arready) begin
                ram_rvalid <= 1'b1;
                ram_rdata  <= mem[m_araddr[9:2]];
            end else if (ram_rvalid && m_rready) begin
                ram_rvalid <= 1'b0;
            end
            if (aw_have && w_have && !ram_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_eff[b]) mem[aw_addr_eff[9:2]][8*b +: 8] <= w_data_eff[8*b +: 8];
                ram_bvalid <= 1'b1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                if (ram_aw_hs) begin
                    aw_got    <= 1'b1;
                    aw_addr_q <= m_awaddr;
                end
                if (ram_w_hs) begin
                    w_got    <= 1'b1;
                    w_data_q <= m_wdata;
                    w_strb_q <= m_wstrb;
                end
            end
            if (ram_bvalid && m_bready) ram_bvalid <= 1'b0;
        end
    end

    int b_count = 0;
    always @(posedge clk) begin
        if (m_bvalid && m_bready) b_count <= b_count + 1;
    end

    // ---------------- helpers --------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] all_handshakes();
        return {s_instr_arready, s_instr_rvalid, s_data_arready, s_data_rvalid,
                s_data_awready, s_data_wready, s_data_bvalid,
                m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};
    endfunction

    // kind: 0 instruction read, 1 data read, 2 data write
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] exp_g, input logic [31:0] exp_d, input string nm);
        int  cnt;
        logic hs_aw;
        logic hs_w;
        case (kind)
            0: begin s_instr_araddr = addr; s_instr_arvalid = 1'b1; s_instr_rready = 1'b1; end
            1: begin s_data_araddr = addr; s_data_arvalid = 1'b1; s_data_rready = 1'b1; end
            default: begin
                s_data_awaddr = addr; s_data_awvalid = 1'b1;
                s_data_wdata = wdata; s_data_wstrb = 4'hF; s_data_wvalid = 1'b1;
                s_data_bready = 1'b1;
            end
        endcase
        #1;
        chk({nm, "_idle_quiet"}, 32'(all_handshakes()), 32'h0);
        step();
        chk({nm, "_grant"}, 32'(grant), 32'(exp_g));
        if (kind < 2) begin
            step();
            s_instr_arvalid = 1'b0;
            s_data_arvalid  = 1'b0;
            cnt = 0;
            while (!(kind == 0 ? s_instr_rvalid : s_data_rvalid) && cnt < 20) begin
                step();
                cnt++;
            end
            chk({nm, "_rvalid"}, 32'(kind == 0 ? s_instr_rvalid : s_data_rvalid), 32'h1);
            chk({nm, "_rdata"}, (kind == 0 ? s_instr_rdata : s_data_rdata), exp_d);
            if (kind == 0)
                chk({nm, "_other_quiet"}, 32'({s_data_arready, s_data_rvalid}), 32'h0);
            else
                chk({nm, "_other_quiet"}, 32'({s_instr_arready, s_instr_rvalid}), 32'h0);
        end else begin
            cnt = 0;
            while ((s_data_awvalid || s_data_wvalid) && cnt < 20) begin
                hs_aw = s_data_awvalid && s_data_awready;
                hs_w  = s_data_wvalid && s_data_wready;
                step();
                if (hs_aw) s_data_awvalid = 1'b0;
                if (hs_w)  s_data_wvalid  = 1'b0;
                cnt++;
            end
            cnt = 0;
            while (!s_data_bvalid && cnt < 20) begin
                step();
                cnt++;
            end
            chk({nm, "_bvalid"}, 32'(s_data_bvalid), 32'h1);
            chk({nm, "_bresp"}, 32'(s_data_bresp), 32'h0);
            s_data_awvalid = 1'b0;
            s_data_wvalid  = 1'b0;
        end
        step();
        chk({nm, "_back_idle"}, 32'(grant), 32'h0);
        s_instr_rready = 1'b0;
        s_data_rready  = 1'b0;
        s_data_bready  = 1'b0;
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_bad %0d", n_bad);
        $fatal(1);
    end

    initial begin
        int          cnt;
        int          b0;
        logic [1:0]  cont_g [4];
        logic [31:0] cont_d [4];

        vecs[0] = '{0, 32'h0000_0010, 32'h0,         2'b01, 32'h0000_0013};
        vecs[1] = '{1, 32'h0000_0020, 32'h0,         2'b10, 32'hA5A5_0008};
        vecs[2] = '{2, 32'h0000_0100, 32'hCAFE_F00D, 2'b11, 32'h0};
        vecs[3] = '{1, 32'h0000_0100, 32'h0,         2'b10, 32'hCAFE_F00D};
        vecs[4] = '{2, 32'h0000_03FC, 32'h1234_5678, 2'b11, 32'h0};
        vecs[5] = '{0, 32'h0000_03FC, 32'h0,         2'b01, 32'h1234_5678};
        vecs[6] = '{0, 32'h0000_0104, 32'h0,         2'b01, 32'hA5A5_0041};

        cont_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        cont_d = '{32'hA5A5_0008, 32'h0000_0013, 32'hA5A5_0008, 32'h0000_0013};

        rst = 1'b1;
        s_instr_araddr = 32'h0; s_instr_arvalid = 1'b0; s_instr_rready = 1'b0;
        s_data_araddr = 32'h0; s_data_arvalid = 1'b0; s_data_rready = 1'b0;
        s_data_awaddr = 32'h0; s_data_awvalid = 1'b0;
        s_data_wdata = 32'h0; s_data_wstrb = 4'h0; s_data_wvalid = 1'b0;
        s_data_bready = 1'b0;

        step();
        step();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_handshakes", 32'(all_handshakes()), 32'h0);
        rst = 1'b0;
        step();

        // table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].exp_g, vecs[i].exp_d,
                   $sformatf("vec%0d", i));
            step();
        end

        // write and read issued together: write first, read sees new data
        s_data_awaddr = 32'h0000_0100; s_data_awvalid = 1'b1;
        s_data_wdata = 32'hDEAD_BEEF; s_data_wstrb = 4'hF; s_data_wvalid = 1'b1;
        s_data_araddr = 32'h0000_0100; s_data_arvalid = 1'b1;
        s_data_bready = 1'b1; s_data_rready = 1'b1;
        step();
        chk("wr_rd_grant_write", 32'(grant), 32'h3);
        chk("wr_rd_ar_blocked", 32'(s_data_arready), 32'h0);
        step();
        s_data_awvalid = 1'b0;
        s_data_wvalid  = 1'b0;
        chk("wr_rd_bvalid", 32'(s_data_bvalid), 32'h1);
        chk("wr_rd_bresp", 32'(s_data_bresp), 32'h0);
        step();
        chk("wr_rd_idle_gap", 32'(grant), 32'h0);
        step();
        chk("wr_rd_grant_read", 32'(grant), 32'h2);
        step();
        s_data_arvalid = 1'b0;
        chk("wr_rd_rdata", s_data_rdata, 32'hDEAD_BEEF);
        chk("wr_rd_rvalid", 32'(s_data_rvalid), 32'h1);
        step();
        chk("wr_rd_back_idle", 32'(grant), 32'h0);
        s_data_bready = 1'b0; s_data_rready = 1'b0;
        step();

        // split write: W arrives three cycles after AW
        b0 = b_count;
        s_data_awaddr = 32'h0000_0200; s_data_awvalid = 1'b1;
        s_data_wdata = 32'h1122_3344; s_data_wstrb = 4'hF; s_data_wvalid = 1'b0;
        s_data_bready = 1'b1;
        step();
        chk("split_grant", 32'(grant), 32'h3);
        chk("split_m_awvalid_on", 32'(m_awvalid), 32'h1);
        step();
        chk("split_aw_dropped", 32'(m_awvalid), 32'h0);
        chk("split_awready_gated", 32'(s_data_awready), 32'h0);
        step();
        chk("split_aw_still_dropped", 32'(m_awvalid), 32'h0);
        s_data_wvalid = 1'b1;
        step();
        chk("split_w_dropped", 32'(m_wvalid), 32'h0);
        chk("split_bvalid", 32'(s_data_bvalid), 32'h1);
        chk("split_still_write", 32'(grant), 32'h3);
        s_data_awvalid = 1'b0;
        s_data_wvalid  = 1'b0;
        step();
        chk("split_back_idle", 32'(grant), 32'h0);
        s_data_bready = 1'b0;
        step();
        step();
        chk("split_single_b", 32'(b_count - b0), 32'h1);
        do_txn(1, 32'h0000_0200, 32'h0, 2'b10, 32'h1122_3344, "split_readback");
        step();

        // backpressure on the instruction R channel with a data request waiting
        s_instr_araddr = 32'h0000_0010; s_instr_arvalid = 1'b1; s_instr_rready = 1'b0;
        step();
        chk("bp_grant", 32'(grant), 32'h1);
        s_data_araddr = 32'h0000_0020; s_data_arvalid = 1'b1; s_data_rready = 1'b1;
        step();
        s_instr_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold_grant_%0d", c), 32'(grant), 32'h1);
            chk($sformatf("bp_rvalid_%0d", c), 32'(s_instr_rvalid), 32'h1);
            chk($sformatf("bp_rdata_%0d", c), s_instr_rdata, 32'h0000_0013);
            chk($sformatf("bp_data_blocked_%0d", c), 32'({s_data_arready, s_data_rvalid}), 32'h0);
            step();
        end
        s_instr_rready = 1'b1;
        step();
        chk("bp_release_idle", 32'(grant), 32'h0);
        step();
        chk("bp_data_granted", 32'(grant), 32'h2);
        step();
        s_data_arvalid = 1'b0;
        chk("bp_data_rdata", s_data_rdata, 32'hA5A5_0008);
        step();
        chk("bp_back_idle", 32'(grant), 32'h0);
        s_instr_rready = 1'b0; s_data_rready = 1'b0;

        // contention from reset: both masters hold arvalid for four transactions
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_instr_araddr = 32'h0000_0010; s_instr_arvalid = 1'b1; s_instr_rready = 1'b1;
        s_data_araddr  = 32'h0000_0020; s_data_arvalid  = 1'b1; s_data_rready  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cnt = 0;
            while (grant == 2'b00 && cnt < 20) begin
                step();
                cnt++;
            end
            chk($sformatf("rr_grant_%0d", t), 32'(grant), 32'(cont_g[t]));
            cnt = 0;
            while (!(s_instr_rvalid || s_data_rvalid) && cnt < 20) begin
                step();
                cnt++;
            end
            chk($sformatf("rr_rdata_%0d", t),
                (grant == 2'b01) ? s_instr_rdata : s_data_rdata, cont_d[t]);
            if (t == 3) begin
                s_instr_arvalid = 1'b0;
                s_data_arvalid  = 1'b0;
            end
            step();
            chk($sformatf("rr_idle_gap_%0d", t), 32'(grant), 32'h0);
        end
        s_instr_rready = 1'b0; s_data_rready = 1'b0;
        step();

        // reset while a data read is waiting on R
        s_data_araddr = 32'h0000_0020; s_data_arvalid = 1'b1; s_data_rready = 1'b0;
        step();
        chk("rst_mid_grant", 32'(grant), 32'h2);
        step();
        s_data_arvalid = 1'b0;
        chk("rst_mid_rvalid_pending", 32'(s_data_rvalid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_async_grant", 32'(grant), 32'h0);
        chk("rst_mid_async_quiet", 32'(all_handshakes()), 32'h0);
        step();
        rst = 1'b0;
        step();
        do_txn(0, 32'h0000_0010, 32'h0, 2'b01, 32'h0000_0013, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
